// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg -- types and constants shared by the serial deserializer blocks.
//   state_t    : deserializer FSM states (PAR is only reachable when the
//                parity feature is compiled in)
//   MSB_FIRST  : msb_first value selecting most-significant-bit-first order
//   LSB_FIRST  : msb_first value selecting least-significant-bit-first order
// ----------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   localparam logic MSB_FIRST = 1'b1;
   localparam logic LSB_FIRST = 1'b0;

endpackage : shift_pkg

// File: rtl/deser_bit_cnt.sv
// ----------------------------------------------------------------------------
// deser_bit_cnt -- counts accepted data bits within one frame.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the count
//   clr  : synchronous clear (frame start / restart)
//   en   : advance by one; wraps to 0 after the terminal count
//   tc   : high while the count equals N-1 (next accepted bit is the last)
// ----------------------------------------------------------------------------
module deser_bit_cnt #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt;

   assign tc = (cnt == CW'(N - 1));

   // NOTE: state registers update with non-blocking assignments only, so every
   // always_ff reads the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         // Explicit wrap keeps non-power-of-two N correct.
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule : deser_bit_cnt

// File: rtl/shift_deser.sv
// ----------------------------------------------------------------------------
// shift_deser -- serial-to-parallel deserializer with a one-word output
// holding register and ready/valid handshake.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   sin       : serial data bit, qualified by sin_vld
//   sin_vld   : one bit accepted per cycle while high (ignored in IDLE)
//   start     : begin a new frame; restarts any frame in progress
//   msb_first : bit order, latched on the start cycle (MSB_FIRST/LSB_FIRST)
//   q         : last assembled word
//   q_vld     : q holds an unconsumed word
//   q_rdy     : consumer takes q when q_vld && q_rdy
//   busy      : frame in progress
//   ovr       : sticky overrun, a completed word was dropped (clears on rst)
//   par_err   : even-parity error of the word in q
// Build option: define SHIFT_DESER_PARITY_EN to expect one even-parity bit
// after the N data bits; otherwise par_err is constant 0.
// ----------------------------------------------------------------------------
module shift_deser
   import shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sin,
   input  logic         sin_vld,
   input  logic         start,
   input  logic         msb_first,
   output logic [N-1:0] q,
   output logic         q_vld,
   input  logic         q_rdy,
   output logic         busy,
   output logic         ovr,
   output logic         par_err
);

   state_t       state, state_nxt;
   logic [N-1:0] shreg, shifted, word;
   logic         msb_r;
   logic         cnt_clr, cnt_en, tc;
   logic         shift_en, complete, load;

   deser_bit_cnt #(.N(N)) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (tc)
   );

   always_comb begin
      shifted = (msb_r == LSB_FIRST) ? {sin, shreg[N-1:1]} : {shreg[N-2:0], sin};
   end

   // NOTE: every output of this block is given a default first so that no path
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      shift_en  = 1'b0;
      complete  = 1'b0;
      word      = shifted;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
               cnt_clr   = 1'b1;
            end
         end
         SHIFT: begin
            // start wins over sin_vld: the partial frame is abandoned.
            if (start) begin
               cnt_clr = 1'b1;
            end else if (sin_vld) begin
               shift_en = 1'b1;
               cnt_en   = 1'b1;
               if (tc) begin
`ifdef SHIFT_DESER_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = IDLE;
                  complete  = 1'b1;
`endif
               end
            end
         end
         PAR: begin
            if (start) begin
               state_nxt = SHIFT;
               cnt_clr   = 1'b1;
            end else if (sin_vld) begin
               // The data word is already assembled; this bit is parity only.
               state_nxt = IDLE;
               complete  = 1'b1;
               word      = shreg;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A completed word is taken only if the holding register is free or is
   // being emptied in this same cycle; otherwise it is dropped as an overrun.
   assign load = complete && (!q_vld || q_rdy);
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the shift register and output word are cleared by reset so that a
   // frame abandoned by rst can never surface as stale data in q.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         msb_r <= MSB_FIRST;
         q     <= '0;
         q_vld <= 1'b0;
         ovr   <= 1'b0;
      end else begin
         if (start)    msb_r <= msb_first;
         if (shift_en) shreg <= shifted;
         if (load) begin
            q     <= word;
            q_vld <= 1'b1;
         end else begin
            if (complete)          ovr   <= 1'b1;
            if (q_vld && q_rdy)    q_vld <= 1'b0;
         end
      end
   end

`ifdef SHIFT_DESER_PARITY_EN
   logic par_r;

   always_ff @(posedge clk) begin
      if (rst)       par_r <= 1'b0;
      else if (load) par_r <= (^shreg) ^ sin;
   end

   assign par_err = par_r;
`else
   assign par_err = 1'b0;
`endif

endmodule : shift_deser

// File: tb/tb_shift_deser.sv
// ----------------------------------------------------------------------------
// tb_shift_deser -- directed self-checking bench for shift_deser (N=8).
// Define SHIFT_DESER_PARITY_EN for both bench and RTL to cover the parity build.
// ----------------------------------------------------------------------------
module tb_shift_deser;
   import shift_pkg::*;

   logic       clk = 1'b0;
   logic       rst, sin, sin_vld, start, msb_first, q_rdy;
   logic [7:0] q;
   logic       q_vld, busy, ovr, par_err;

   int n_total = 0;
   int n_bad   = 0;

   shift_deser #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_vld   (sin_vld),
      .start     (start),
      .msb_first (msb_first),
      .q         (q),
      .q_vld     (q_vld),
      .q_rdy     (q_rdy),
      .busy      (busy),
      .ovr       (ovr),
      .par_err   (par_err)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin     = b;
      sin_vld = 1'b1;
      step();
      sin_vld = 1'b0;
      sin     = 1'b0;
   endtask

   task automatic do_start(input logic order);
      start     = 1'b1;
      msb_first = order;
      step();
      start     = 1'b0;
   endtask

   // Even-parity bit closing a frame (parity build only), so par_err stays 0.
   task automatic send_par(input logic [7:0] w);
`ifdef SHIFT_DESER_PARITY_EN
      send_bit(^w);
`else
      if (w === 8'hxx) $display("note: undefined word");
`endif
   endtask

   task automatic send_word(input logic [7:0] w, input logic order);
      do_start(order);
      for (int i = 0; i < 8; i++) send_bit(order ? w[7-i] : w[i]);
      send_par(w);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; msb_first = 1'b1; sin_vld = 1'b1; sin = 1'b1;
      step();
      step();
      n_total++; if (q !== 8'h00)  begin n_bad++; $display("FAIL rst_q: got %h want 00", q); end
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL rst_q_vld: got %b want 0", q_vld); end
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_total++; if (ovr !== 1'b0)  begin n_bad++; $display("FAIL rst_ovr: got %b want 0", ovr); end
      n_total++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL rst_par_err: got %b want 0", par_err); end
      rst = 1'b0; start = 1'b0; sin_vld = 1'b0; sin = 1'b0;
      step();
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_msb_first;
      do_start(MSB_FIRST);
      n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL msb_busy: got %b want 1", busy); end
      for (int i = 0; i < 8; i++) begin
         send_bit(i == 7);
         if (i < 7) begin
            n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL msb_early_vld bit %0d: got %b want 0", i, q_vld); end
         end
      end
      send_par(8'h01);
      n_total++; if (q !== 8'h01)    begin n_bad++; $display("FAIL msb_q: got %h want 01", q); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL msb_q_vld: got %b want 1", q_vld); end
      n_total++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL msb_busy_end: got %b want 0", busy); end
      n_total++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL msb_par_err: got %b want 0", par_err); end
      step();
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL msb_consume: got %b want 0", q_vld); end
      n_total++; if (q !== 8'h01)    begin n_bad++; $display("FAIL msb_q_hold: got %h want 01", q); end
   endtask

   task automatic test_lsb_first;
      do_start(LSB_FIRST);
      for (int i = 0; i < 8; i++) send_bit(i == 7);
      send_par(8'h80);
      n_total++; if (q !== 8'h80)    begin n_bad++; $display("FAIL lsb_q: got %h want 80", q); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL lsb_q_vld: got %b want 1", q_vld); end
      step();
   endtask

   task automatic test_overrun;
      q_rdy = 1'b0;
      send_word(8'h11, MSB_FIRST);
      n_total++; if (q !== 8'h11)  begin n_bad++; $display("FAIL ovr_first_q: got %h want 11", q); end
      n_total++; if (ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_first_ovr: got %b want 0", ovr); end
      send_word(8'h22, MSB_FIRST);
      n_total++; if (q !== 8'h11)    begin n_bad++; $display("FAIL ovr_q_kept: got %h want 11", q); end
      n_total++; if (ovr !== 1'b1)   begin n_bad++; $display("FAIL ovr_set: got %b want 1", ovr); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL ovr_q_vld: got %b want 1", q_vld); end
      q_rdy = 1'b1;
      step();
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got %b want 0", q_vld); end
      n_total++; if (ovr !== 1'b1)   begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
      n_total++; if (q !== 8'h11)    begin n_bad++; $display("FAIL ovr_q_after: got %h want 11", q); end
   endtask

   task automatic test_restart;
      // Hold q_rdy low so any premature completion would stay visible in q_vld.
      q_rdy = 1'b0;
      do_start(LSB_FIRST);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      do_start(MSB_FIRST);
      for (int i = 0; i < 8; i++) begin
         step();
         n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL restart_early_vld bit %0d: got %b want 0", i, q_vld); end
         send_bit(1'b1);
      end
      send_par(8'hFF);
      n_total++; if (q !== 8'hFF)    begin n_bad++; $display("FAIL restart_q: got %h want ff", q); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL restart_q_vld: got %b want 1", q_vld); end
      q_rdy = 1'b1;
      step();
   endtask

   task automatic test_mid_reset;
      do_start(MSB_FIRST);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_total++; if (q !== 8'h00)    begin n_bad++; $display("FAIL mrst_q: got %h want 00", q); end
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL mrst_q_vld: got %b want 0", q_vld); end
      n_total++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
      n_total++; if (ovr !== 1'b0)   begin n_bad++; $display("FAIL mrst_ovr: got %b want 0", ovr); end
      send_bit(1'b1);
      send_bit(1'b0);
      n_total++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL idle_ignore_busy: got %b want 0", busy); end
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL idle_ignore_vld: got %b want 0", q_vld); end
      send_word(8'hA5, MSB_FIRST);
      n_total++; if (q !== 8'hA5)    begin n_bad++; $display("FAIL mrst_next_q: got %h want a5", q); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL mrst_next_vld: got %b want 1", q_vld); end
      step();
   endtask

   task automatic test_back_to_back;
      logic [7:0] w;
      w = 8'hC3;
      q_rdy = 1'b0;
      send_word(8'h3C, MSB_FIRST);
      n_total++; if (q !== 8'h3C) begin n_bad++; $display("FAIL b2b_first_q: got %h want 3c", q); end
      do_start(MSB_FIRST);
      for (int i = 0; i < 7; i++) send_bit(w[7-i]);
`ifdef SHIFT_DESER_PARITY_EN
      send_bit(w[0]);
      q_rdy = 1'b1;
      send_bit(^w);
`else
      q_rdy = 1'b1;
      send_bit(w[0]);
`endif
      n_total++; if (q !== 8'hC3)    begin n_bad++; $display("FAIL b2b_q: got %h want c3", q); end
      n_total++; if (q_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_q_vld: got %b want 1", q_vld); end
      n_total++; if (ovr !== 1'b0)   begin n_bad++; $display("FAIL b2b_ovr: got %b want 0", ovr); end
      step();
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", q_vld); end
   endtask

`ifdef SHIFT_DESER_PARITY_EN
   task automatic test_parity;
      logic [7:0] w;
      w = 8'hA5;
      do_start(MSB_FIRST);
      for (int i = 0; i < 8; i++) send_bit(w[7-i]);
      n_total++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL par_wait_busy: got %b want 1", busy); end
      n_total++; if (q_vld !== 1'b0) begin n_bad++; $display("FAIL par_wait_vld: got %b want 0", q_vld); end
      send_bit(1'b1);
      n_total++; if (q !== 8'hA5)      begin n_bad++; $display("FAIL par1_q: got %h want a5", q); end
      n_total++; if (par_err !== 1'b1) begin n_bad++; $display("FAIL par1_err: got %b want 1", par_err); end
      step();
      do_start(MSB_FIRST);
      for (int i = 0; i < 8; i++) send_bit(w[7-i]);
      send_bit(1'b0);
      n_total++; if (q !== 8'hA5)      begin n_bad++; $display("FAIL par0_q: got %h want a5", q); end
      n_total++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL par0_err: got %b want 0", par_err); end
      step();
   endtask
`endif

   initial begin
      rst = 1'b1; sin = 1'b0; sin_vld = 1'b0; start = 1'b0;
      msb_first = 1'b1; q_rdy = 1'b1;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_overrun();
      test_restart();
      test_mid_reset();
      test_back_to_back();
`ifdef SHIFT_DESER_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_shift_deser

// File: doc/shift_deser.md
SHIFT_DESER -- requirements
Module: shift_deser

Interface
REQ-001 Parameter N, default 8, word width in bits; N >= 2.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 sin  in  1  serial data bit.
REQ-005 sin_vld  in  1  sin qualifier; one bit accepted per cycle with sin_vld=1.
REQ-006 start  in  1  begin new frame.
REQ-007 msb_first  in  1  bit order, sampled only on the start cycle; 1=MSB first, 0=LSB first.
REQ-008 q  out  N  last assembled word.
REQ-009 q_vld  out  1  q holds an unconsumed word.
REQ-010 q_rdy  in  1  consumer accepts q when q_vld=1 and q_rdy=1.
REQ-011 busy  out  1  frame in progress (state not IDLE).
REQ-012 ovr  out  1  sticky overrun flag.
REQ-013 par_err  out  1  parity error of the word in q; port present in all builds.

Function
REQ-014 States SHALL be IDLE, SHIFT and PAR; PAR exists only when parity is compiled in.
REQ-015 IDLE: sin/sin_vld ignored; start=1 -> SHIFT, bit count cleared, msb_first latched.
REQ-016 SHIFT, sin_vld=1: MSB-first -> shift reg = {shreg[N-2:0], sin}; LSB-first -> shreg = {sin, shreg[N-1:1]}; bit count +1.
REQ-017 SHIFT, sin_vld=0: shreg and bit count hold.
REQ-018 Nth accepted bit -> word complete (no parity) or -> PAR (parity); bit count wraps to 0.
REQ-019 Word complete: q_vld=1 and q=word in the cycle after the completing bit (latency 1); state -> IDLE.
REQ-020 q_vld=1 and q_rdy=1 with no completion in that cycle: q_vld -> 0 next cycle; q holds its value.
REQ-021 Completion with q_vld=1, q_rdy=0: new word dropped; q unchanged; ovr -> 1.
REQ-022 Completion with q_vld=1, q_rdy=1: new word loaded; q_vld stays 1; ovr unchanged.
REQ-023 start=1 in SHIFT or PAR: partial frame abandoned; count cleared; msb_first relatched; stay in/return to SHIFT; sin_vld on that cycle ignored.
REQ-024 ovr SHALL clear only on rst.
REQ-025 busy=1 in SHIFT and PAR, 0 in IDLE.

Reset
REQ-026 rst=1 at a clock edge SHALL force: state IDLE, count 0, shreg 0, q 0, q_vld 0, ovr 0, par_err 0; rst has priority over every other input.
REQ-027 rst mid-frame SHALL discard the partial word; the next start SHALL begin a clean frame.

Configuration
REQ-028 Macro SHIFT_DESER_PARITY_EN defined: after N data bits, one more sin_vld bit in PAR is the even-parity bit; on that bit the word completes and par_err = XOR(data bits, parity bit), loaded with q under REQ-019..022.
REQ-029 Macro undefined: no PAR state; word completes on the Nth bit; par_err tied to 0.

Structure
REQ-030 Shared package shift_pkg SHALL hold the state typedef (IDLE/SHIFT/PAR) and the bit-order constants MSB_FIRST=1 and LSB_FIRST=0.
REQ-031 Optional sub-module deser_bit_cnt: clog2(N)-bit counter with clear, enable and terminal-count output; all other logic in shift_deser.

Verification (N=8, q_rdy=1 unless stated)
REQ-032 msb_first=1, bits 0,0,0,0,0,0,0,1 -> q=0x01, q_vld=1 one cycle after the 8th bit, busy=0.
REQ-033 msb_first=0, same bit sequence -> q=0x80.
REQ-034 q_rdy=0: frame 0x11 then frame 0x22 -> q stays 0x11, ovr=1; set q_rdy=1 -> q_vld drops next cycle, ovr stays 1.
REQ-035 3 bits, then start, then 8 ones with gaps in sin_vld -> q=0xFF, no early q_vld.
REQ-036 rst after 4 bits -> q=0, q_vld=0, busy=0, ovr=0; next frame 0xA5 -> q=0xA5.
REQ-037 SHIFT_DESER_PARITY_EN defined: 0xA5 with parity bit 1 -> par_err=1; 0xA5 with parity bit 0 -> par_err=0.
